// File: rtl/qram_access_sequencer.sv
// qram_access_sequencer
// Accepts one read or write request at a time, shifts the cell address out
// LSB first on AddressQBit, then issues a single-cycle Write or Read strobe.
// Reads sample outputQBit a fixed number of cycles after the strobe and
// return the bit through a valid/ready response handshake.
module qram_access_sequencer #(
    parameter int ADDR_WIDTH   = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic                  DDRClockP,
    input  logic                  ResetN,
    input  logic                  ReqValid,
    output logic                  ReqReady,
    input  logic                  ReqWrite,
    input  logic [ADDR_WIDTH-1:0] ReqAddress,
    input  logic                  ReqData,
    output logic                  RspValid,
    input  logic                  RspReady,
    output logic                  RspData,
    output logic                  AddressQBit,
    output logic                  inputQBit,
    output logic                  Write,
    output logic                  Read,
    input  logic                  outputQBit,
    output logic                  Busy
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHIFT  = 3'd1,
        ST_STROBE = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    // Terminal counts: last address bit index and last wait cycle index.
    localparam logic [4:0] LAST_BIT = 5'(ADDR_WIDTH - 1);
    localparam logic [3:0] LAST_LAT = 4'(READ_LATENCY - 1);

    state_t                state_r;
    logic [ADDR_WIDTH-1:0] shift_r;   // remaining address bits, next bit in [0]
    logic                  write_r;   // latched request direction
    logic [4:0]            bit_cnt_r; // index of the bit currently on AddressQBit
    logic [3:0]            lat_cnt_r; // WAIT cycles already elapsed

    // Sequencer FSM; every output is a register updated alongside the state.
    always_ff @(posedge DDRClockP or negedge ResetN) begin
        if (!ResetN) begin
            state_r     <= ST_IDLE;
            shift_r     <= '0;
            write_r     <= 1'b0;
            bit_cnt_r   <= 5'd0;
            lat_cnt_r   <= 4'd0;
            ReqReady    <= 1'b1;
            RspValid    <= 1'b0;
            RspData     <= 1'b0;
            AddressQBit <= 1'b0;
            inputQBit   <= 1'b0;
            Write       <= 1'b0;
            Read        <= 1'b0;
            Busy        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ReqValid && ReqReady) begin
                        // Bit 0 goes out in the first SHIFT cycle, so it is
                        // presented straight from the request on the accept edge.
                        AddressQBit <= ReqAddress[0];
                        shift_r     <= ReqAddress >> 1'b1;
                        write_r     <= ReqWrite;
                        inputQBit   <= ReqWrite & ReqData;
                        bit_cnt_r   <= 5'd0;
                        ReqReady    <= 1'b0;
                        Busy        <= 1'b1;
                        state_r     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (bit_cnt_r == LAST_BIT) begin
                        AddressQBit <= 1'b0;
                        Write       <= write_r;
                        Read        <= ~write_r;
                        bit_cnt_r   <= 5'd0;
                        state_r     <= ST_STROBE;
                    end else begin
                        AddressQBit <= shift_r[0];
                        shift_r     <= shift_r >> 1'b1;
                        bit_cnt_r   <= bit_cnt_r + 5'd1;
                    end
                end
                ST_STROBE: begin
                    Write     <= 1'b0;
                    Read      <= 1'b0;
                    inputQBit <= 1'b0;
                    if (write_r) begin
                        ReqReady <= 1'b1;
                        Busy     <= 1'b0;
                        state_r  <= ST_IDLE;
                    end else begin
                        lat_cnt_r <= 4'd0;
                        state_r   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (lat_cnt_r == LAST_LAT) begin
                        RspData  <= outputQBit;
                        RspValid <= 1'b1;
                        state_r  <= ST_RESP;
                    end else begin
                        lat_cnt_r <= lat_cnt_r + 4'd1;
                    end
                end
                ST_RESP: begin
                    if (RspReady) begin
                        RspValid <= 1'b0;
                        ReqReady <= 1'b1;
                        Busy     <= 1'b0;
                        state_r  <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    ReqReady    <= 1'b1;
                    RspValid    <= 1'b0;
                    AddressQBit <= 1'b0;
                    inputQBit   <= 1'b0;
                    Write       <= 1'b0;
                    Read        <= 1'b0;
                    Busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule
